// File: rtl/pipelined_mux_n.sv
// rtl/pipelined_mux_n.sv - registered N:1 word selector with fixed-select and round-robin modes
module pipelined_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             fix_ok;
  logic             rr_found;
  logic [SEL_W-1:0] rr_grant;
  logic             grant_ok;
  logic [SEL_W-1:0] grant_idx;
  logic             in_xfer;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid_q || out_ready;
  assign fix_ok  = ({1'b0, sel} < NUM_IN_X);

  // Descending scan so the candidate closest to rr_ptr_q is the last one written.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      int c;
      c = int'(rr_ptr_q) + k;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (in_valid[c]) begin
        rr_found = 1'b1;
        rr_grant = SEL_W'(c);
      end
    end
  end

  assign grant_idx = mode ? rr_grant : sel;
  assign grant_ok  = mode ? rr_found : fix_ok;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = rst_n && grant_ok && load_en && (grant_idx == SEL_W'(i));
      if (grant_idx == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_xfer = |(in_ready & in_valid);

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (in_xfer) begin
      out_data_d  = sel_data;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      if (mode) rr_ptr_d = (rr_grant == LAST_IDX) ? '0 : rr_grant + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_mux_n.sv
// tb/tb_pipelined_mux_n.sv - scoreboard bench for pipelined_mux_n
module tb_pipelined_mux_n;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [1:0]     sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_valid;
  logic           out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic           mode3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_src3;
  logic           out_valid3;
  logic           out_ready3;

  int tests = 0;
  int fails = 0;

  logic [W+1:0] exp_q[$];
  logic [1:0]   src_log[$];
  int           m_rr;
  logic         m_valid;

  pipelined_mux_n #(.WIDTH(W), .NUM_IN(N), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  pipelined_mux_n #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who should be offered a slot, derived from the selection rules directly.
  function automatic logic [N-1:0] model_ready(input logic md, input logic [1:0] s,
                                               input logic [N-1:0] v, input int ptr,
                                               input logic ov, input logic ordy);
    if (ov && !ordy) return '0;
    if (!md) return (int'(s) < N) ? N'(1 << s) : '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return N'(1 << i);
    end
    return '0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_rr    = 0;
      exp_q.delete();
    end else begin
      logic [N-1:0] r;
      int g;
      r = model_ready(mode, sel, in_valid, m_rr, m_valid, out_ready);
      check("in_ready", 64'(in_ready), 64'(r));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      g = -1;
      for (int i = 0; i < N; i++) if (r[i] && in_valid[i]) g = i;
      if (g >= 0) begin
        exp_q.push_back({2'(g), in_data[g*W +: W]});
        if (mode) m_rr = (g + 1) % N;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e[W-1:0]));
        check("out_src", 64'(out_src), 64'(e[W+1:W]));
      end
      src_log.push_back(out_src);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_rr[6];
    logic [1:0] exp_single[5];
    exp_rr     = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    exp_single = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0};

    rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
    in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    check("reset_out_src", 64'(out_src), 64'(0));
    repeat (2) cyc();
    rst_n = 1'b1;

    // fixed pass-through
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_data[2*W +: W] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      #1 check("fixed_in_ready", 64'(in_ready), 64'(4'b0100));
      cyc();
      check("fixed_data", 64'(out_data), 64'(32'hDEADBEEF));
      check("fixed_src", 64'(out_src), 64'(2));
    end

    // backpressure
    out_ready = 1'b0;
    repeat (3) begin
      cyc();
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_data", 64'(out_data), 64'(32'hDEADBEEF));
    end
    sel = 2'd1; in_data[1*W +: W] = 32'h12345678;
    cyc();
    check("stall_after_sel", 64'(out_data), 64'(32'hDEADBEEF));
    out_ready = 1'b1;
    cyc();
    check("reload_data", 64'(out_data), 64'(32'h12345678));
    check("reload_src", 64'(out_src), 64'(1));
    check("reload_valid", 64'(out_valid), 64'(1));

    // asynchronous reset mid-cycle with a word held
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'(0));
    check("async_out_data", 64'(out_data), 64'(0));
    check("async_out_src", 64'(out_src), 64'(0));
    check("async_in_ready", 64'(in_ready), 64'(0));
    cyc();
    rst_n = 1'b1;

    // round-robin fairness
    src_log.delete();
    mode = 1'b1; in_valid = 4'b1011; out_ready = 1'b1;
    repeat (6) cyc();
    in_valid = '0;
    cyc();
    check("rr_log_len", 64'(src_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < src_log.size(); i++)
      check("rr_seq", 64'(src_log[i]), 64'(exp_rr[i]));

    // round-robin single requester
    src_log.delete();
    in_valid = 4'b1000;
    repeat (3) cyc();
    in_valid = 4'b0001;
    repeat (2) cyc();
    in_valid = '0;
    cyc();
    check("single_log_len", 64'(src_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < src_log.size(); i++)
      check("single_seq", 64'(src_log[i]), 64'(exp_single[i]));

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      cyc();
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (3) cyc();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    // out-of-range select on a 3-input instance
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {32'h33333333, 32'h22222222, 32'hA5A5_0001};
    repeat (3) begin
      cyc();
      check("badsel_in_ready", 64'(in_ready3), 64'(0));
      check("badsel_out_valid", 64'(out_valid3), 64'(0));
    end
    sel3 = 2'd0;
    #1 check("sel0_in_ready", 64'(in_ready3), 64'(3'b001));
    cyc();
    check("sel0_valid", 64'(out_valid3), 64'(1));
    check("sel0_data", 64'(out_data3), 64'(32'hA5A5_0001));
    check("sel0_src", 64'(out_src3), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
